// File: rtl/video_timing_pkg.sv
// Shared raster timing types and helpers for the video output engine.
//   timing_t     : per-axis active / front porch / sync / back porch lengths
//   axis_total   : total length of an axis
//   sync_start   : first position of the sync window
//   sync_end     : first position after the sync window
//   in_window    : pos inside [lo, hi)
package video_timing_pkg;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned CNT_MAX = 4096;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    function automatic int unsigned axis_total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int unsigned sync_start(timing_t t);
        return t.active + t.fp;
    endfunction

    function automatic int unsigned sync_end(timing_t t);
        return t.active + t.fp + t.sync;
    endfunction

    // Compared at 32 bits so a window ending exactly at 4096 still works.
    function automatic logic in_window(cnt_t pos, int unsigned lo, int unsigned hi);
        int unsigned p;
        p = {20'd0, pos};
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/video_raster_gen.sv
// Raster timing generator: pixel phase, hcnt/vcnt, genlock restart and
// pixel request generation.
//   clk, rst_n    : clock (CLK_DIV x pixel rate), async active-low reset
//   frame_sync_i  : one-clk end-of-source-frame pulse
//   ph_o          : current phase within the pixel period
//   hcnt_o/vcnt_o : current raster position
//   pix_req_o     : registered one-clk request, with x_o/y_o holding position
//   locked_o      : genlock status
module video_raster_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter timing_t     H_T      = '{active: 1280, fp: 440, sync: 40, bp: 220},
    parameter timing_t     V_T      = '{active: 720, fp: 5, sync: 5, bp: 20},
    parameter bit          GENLOCK  = 1'b1,
    parameter int unsigned LOCK_TOL = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_sync_i,
    output logic [$clog2(CLK_DIV)-1:0] ph_o,
    output cnt_t                       hcnt_o,
    output cnt_t                       vcnt_o,
    output logic                       pix_req_o,
    output cnt_t                       x_o,
    output cnt_t                       y_o,
    output logic                       locked_o
);

    localparam int unsigned PH_W  = $clog2(CLK_DIV);
    localparam int unsigned V_TOT = axis_total(V_T);

    typedef logic [PH_W-1:0] ph_t;

    localparam ph_t  PH_LAST  = ph_t'(CLK_DIV - 1);
    localparam cnt_t H_LAST   = cnt_t'(axis_total(H_T) - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOT - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_T.active);
    localparam cnt_t V_ACT    = cnt_t'(V_T.active);
    // Restarting on or after this line counts as in lock.
    localparam cnt_t LOCK_MIN = (LOCK_TOL >= V_TOT - 1) ? '0 : cnt_t'(V_TOT - 1 - LOCK_TOL);

    ph_t  ph_q, ph_d;
    cnt_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    cnt_t x_q, x_d, y_q, y_d;
    logic run_q;
    logic pend_q, pend_d;
    logic locked_q, locked_d;
    logic req_q, req_d;

    always_comb begin
        ph_d     = ph_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        pend_d   = pend_q;
        locked_d = locked_q;
        if (GENLOCK && frame_sync_i) begin
            pend_d = 1'b1;
        end
        // The first clk after reset holds (0,0,ph0) so the registered
        // request for (0,0) shows up in that period.
        if (run_q) begin
            if (ph_q == PH_LAST) begin
                ph_d = '0;
                if (hcnt_q == H_LAST) begin
                    hcnt_d = '0;
                    if (pend_d) begin
                        vcnt_d   = '0;
                        locked_d = (vcnt_q >= LOCK_MIN);
                    end else if (vcnt_q == V_LAST) begin
                        vcnt_d = '0;
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                    pend_d = 1'b0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end else begin
                ph_d = ph_q + 1'b1;
            end
        end
    end

    // Request decoded from next-state so it is registered yet aligned with ph==0.
    always_comb begin
        req_d = (ph_d == '0) && (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        x_d   = req_d ? hcnt_d : x_q;
        y_d   = req_d ? vcnt_d : y_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q     <= '0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            run_q    <= 1'b0;
            pend_q   <= 1'b0;
            locked_q <= !GENLOCK;
            req_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            ph_q     <= ph_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            run_q    <= 1'b1;
            pend_q   <= pend_d;
            locked_q <= locked_d;
            req_q    <= req_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign ph_o      = ph_q;
    assign hcnt_o    = hcnt_q;
    assign vcnt_o    = vcnt_q;
    assign pix_req_o = req_q;
    assign x_o       = x_q;
    assign y_o       = y_q;
    assign locked_o  = locked_q;

endmodule

// File: rtl/video_ddr_out.sv
// Video output engine with DDR pixel serialisation.
//   clk, rst_n          : clock (CLK_DIV x pixel rate), async active-low reset
//   o_pix_req/o_x/o_y   : pixel request to upstream source
//   i_pix/i_pix_valid   : requested pixel, valid by the last phase of the period
//   i_frame_sync        : source end-of-frame pulse for genlock
//   i_clr_status        : clears o_underflow
//   o_clk_pixel         : forwarded pixel clock, edges centred in each half
//   o_de/o_hsync/o_vsync: video control
//   o_data              : upper half then lower half of each pixel
//   o_frame_start       : pulse on first output phase of pixel (0,0)
//   o_locked            : genlock status
//   o_underflow         : sticky missing-pixel flag
module video_ddr_out
    import video_timing_pkg::*;
#(
    parameter int unsigned PIX_W    = 24,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 440,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter bit          GENLOCK  = 1'b1,
    parameter int unsigned LOCK_TOL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               o_pix_req,
    output logic [11:0]        o_x,
    output logic [11:0]        o_y,
    input  logic [PIX_W-1:0]   i_pix,
    input  logic               i_pix_valid,
    input  logic               i_frame_sync,
    input  logic               i_clr_status,
    output logic               o_clk_pixel,
    output logic               o_de,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic [PIX_W/2-1:0] o_data,
    output logic               o_frame_start,
    output logic               o_locked,
    output logic               o_underflow
);

    localparam timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    localparam int unsigned HALF = PIX_W / 2;
    localparam int unsigned PH_W = $clog2(CLK_DIV);

    typedef logic [PH_W-1:0] ph_t;

    localparam ph_t  PH_LAST = ph_t'(CLK_DIV - 1);
    localparam ph_t  PH_Q1   = ph_t'(CLK_DIV / 4);
    localparam ph_t  PH_HALF = ph_t'(CLK_DIV / 2);
    localparam ph_t  PH_Q3   = ph_t'(3 * CLK_DIV / 4);
    localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);

    if ((PIX_W % 2) != 0 || PIX_W == 0) begin : g_bad_pix_w
        $error("PIX_W must be even and non-zero");
    end
    if ((CLK_DIV % 4) != 0 || CLK_DIV < 4) begin : g_bad_clk_div
        $error("CLK_DIV must be a multiple of 4 and at least 4");
    end
    if (axis_total(H_T) > CNT_MAX || axis_total(V_T) > CNT_MAX) begin : g_bad_total
        $error("H_TOTAL and V_TOTAL must not exceed 4096");
    end

    ph_t  ph;
    cnt_t hcnt, vcnt;

    video_raster_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_T      (H_T),
        .V_T      (V_T),
        .GENLOCK  (GENLOCK),
        .LOCK_TOL (LOCK_TOL)
    ) u_raster (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_sync_i (i_frame_sync),
        .ph_o         (ph),
        .hcnt_o       (hcnt),
        .vcnt_o       (vcnt),
        .pix_req_o    (o_pix_req),
        .x_o          (o_x),
        .y_o          (o_y),
        .locked_o     (o_locked)
    );

    // Capture stage: holds the pixel and controls for the period being output.
    logic [PIX_W-1:0] pix_q, pix_d;
    logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic uf_d, uf_set, active;

    always_comb begin
        pix_d  = pix_q;
        de_d   = de_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        fs_d   = fs_q;
        uf_set = 1'b0;
        active = (hcnt < H_ACT) && (vcnt < V_ACT);
        if (ph == PH_LAST) begin
            pix_d  = (active && i_pix_valid) ? i_pix : '0;
            uf_set = active && !i_pix_valid;
            de_d   = active;
            hs_d   = in_window(hcnt, sync_start(H_T), sync_end(H_T)) ? HS_POL : !HS_POL;
            vs_d   = in_window(vcnt, sync_start(V_T), sync_end(V_T)) ? VS_POL : !VS_POL;
            fs_d   = (hcnt == '0) && (vcnt == '0);
        end
        // A new underflow beats a simultaneous clear.
        if (uf_set) begin
            uf_d = 1'b1;
        end else if (i_clr_status) begin
            uf_d = 1'b0;
        end else begin
            uf_d = o_underflow;
        end
    end

    // Output stage: ph of this cycle is the output phase of the next cycle.
    logic [HALF-1:0] data_d;
    logic            clkp_d, fst_d;

    always_comb begin
        data_d = (ph < PH_HALF) ? pix_q[PIX_W-1:HALF] : pix_q[HALF-1:0];
        clkp_d = (ph >= PH_Q1) && (ph < PH_Q3);
        fst_d  = fs_q && (ph == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q         <= '0;
            de_q          <= 1'b0;
            hs_q          <= !HS_POL;
            vs_q          <= !VS_POL;
            fs_q          <= 1'b0;
            o_underflow   <= 1'b0;
            o_data        <= '0;
            o_clk_pixel   <= 1'b0;
            o_de          <= 1'b0;
            o_hsync       <= !HS_POL;
            o_vsync       <= !VS_POL;
            o_frame_start <= 1'b0;
        end else begin
            pix_q         <= pix_d;
            de_q          <= de_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            fs_q          <= fs_d;
            o_underflow   <= uf_d;
            o_data        <= data_d;
            o_clk_pixel   <= clkp_d;
            o_de          <= de_q;
            o_hsync       <= hs_q;
            o_vsync       <= vs_q;
            o_frame_start <= fst_d;
        end
    end

endmodule

// File: tb/tb_video_ddr_out.sv
// Directed bench for video_ddr_out with a 14x7 raster, CLK_DIV=4.
// Cycle index t counts negedges after reset release; t=0 holds the (0,0) request.
module tb_video_ddr_out;

    logic        clk;
    logic        rst_n;
    logic        o_pix_req;
    logic [11:0] o_x, o_y;
    logic [23:0] i_pix;
    logic        i_pix_valid;
    logic        i_frame_sync;
    logic        i_clr_status;
    logic        o_clk_pixel, o_de, o_hsync, o_vsync;
    logic [11:0] o_data;
    logic        o_frame_start, o_locked, o_underflow;

    logic cst_en;
    logic drop_en;

    int n_chk;
    int n_bad;
    int t;

    video_ddr_out #(
        .PIX_W    (24),
        .CLK_DIV  (4),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (2),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1),
        .GENLOCK  (1'b1),
        .LOCK_TOL (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_pix_req     (o_pix_req),
        .o_x           (o_x),
        .o_y           (o_y),
        .i_pix         (i_pix),
        .i_pix_valid   (i_pix_valid),
        .i_frame_sync  (i_frame_sync),
        .i_clr_status  (i_clr_status),
        .o_clk_pixel   (o_clk_pixel),
        .o_de          (o_de),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_data        (o_data),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked),
        .o_underflow   (o_underflow)
    );

    // Source answers with {x,y}; optional fixed pixel at (0,0) and a hole at (3,1).
    assign i_pix       = (cst_en && o_x == 12'd0 && o_y == 12'd0) ? 24'hABCDEF : {o_x, o_y};
    assign i_pix_valid = !(drop_en && o_x == 12'd3 && o_y == 12'd1);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0d: got %0h want %0h", tag, t, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        t++;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        t     = -1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(o_pix_req), 0);
        chk({tag, "_x"}, 32'(o_x), 0);
        chk({tag, "_y"}, 32'(o_y), 0);
        chk({tag, "_clkp"}, 32'(o_clk_pixel), 0);
        chk({tag, "_de"}, 32'(o_de), 0);
        chk({tag, "_data"}, 32'(o_data), 0);
        chk({tag, "_hs"}, 32'(o_hsync), 0);
        chk({tag, "_vs"}, 32'(o_vsync), 0);
        chk({tag, "_fs"}, 32'(o_frame_start), 0);
        chk({tag, "_uf"}, 32'(o_underflow), 0);
        chk({tag, "_lock"}, 32'(o_locked), 0);
    endtask

    initial begin
        int n, h, v, m, p, oh, ov;
        int req_e, de_e, hs_e, vs_e, fs_e, d_e;
        int nreq, nfs, found;

        n_chk        = 0;
        n_bad        = 0;
        t            = 0;
        rst_n        = 1'b1;
        i_frame_sync = 1'b0;
        i_clr_status = 1'b0;
        cst_en       = 1'b0;
        drop_en      = 1'b0;
        #2;

        // Reset values
        hold_reset();
        chk_reset_vals("rst");

        // Free-run frame with fixed (0,0) pixel and missing (3,1) pixel
        cst_en  = 1'b1;
        drop_en = 1'b1;
        release_reset();
        nreq = 0;
        for (int k = 0; k <= 397; k++) begin
            step();
            if (t == 4) cst_en = 1'b0;
            if (t == 80) drop_en = 1'b0;
            n     = t / 4;
            h     = n % 14;
            v     = (n / 14) % 7;
            req_e = (t % 4 == 0 && h < 8 && v < 4) ? 1 : 0;
            chk("req", 32'(o_pix_req), req_e);
            if (req_e == 1) begin
                chk("req_x", 32'(o_x), h);
                chk("req_y", 32'(o_y), v);
            end
            if (o_pix_req && t < 392) nreq++;
            de_e = 0; hs_e = 0; vs_e = 0; fs_e = 0; d_e = 0;
            if (t >= 5) begin
                m    = (t - 5) / 4;
                p    = (t - 5) % 4;
                oh   = m % 14;
                ov   = (m / 14) % 7;
                de_e = (oh < 8 && ov < 4) ? 1 : 0;
                hs_e = (oh == 10 || oh == 11) ? 1 : 0;
                vs_e = (ov == 5) ? 1 : 0;
                fs_e = (p == 0 && oh == 0 && ov == 0) ? 1 : 0;
                if (de_e == 1) begin
                    if (m == 0) d_e = (p < 2) ? 'hABC : 'hDEF;
                    else if (m == 17) d_e = 0;
                    else d_e = (p < 2) ? oh : ov;
                end
            end
            chk("de", 32'(o_de), de_e);
            chk("hsync", 32'(o_hsync), hs_e);
            chk("vsync", 32'(o_vsync), vs_e);
            chk("data", 32'(o_data), d_e);
            chk("fstart", 32'(o_frame_start), fs_e);
            chk("clkp", 32'(o_clk_pixel), (t % 4 >= 2) ? 1 : 0);
            chk("uflow", 32'(o_underflow), (t >= 72) ? 1 : 0);
        end
        chk("req_per_frame", nreq, 32);

        // Clear, then set and clear in the same clk
        i_clr_status = 1'b1;
        step();
        i_clr_status = 1'b0;
        step();
        chk("uf_cleared", 32'(o_underflow), 0);
        i_clr_status = 1'b1;
        drop_en      = 1'b1;
        found        = 0;
        for (int k = 0; k < 600 && found == 0; k++) begin
            step();
            if (o_pix_req && o_x == 12'd3 && o_y == 12'd1) found = 1;
        end
        chk("uf_wait", found, 1);
        if (found == 1) begin
            repeat (4) step();
            chk("uf_set_wins", 32'(o_underflow), 1);
            step();
            chk("uf_clr_after", 32'(o_underflow), 0);
        end
        i_clr_status = 1'b0;
        drop_en      = 1'b0;

        // Genlock: pulse in line 6 (locked), then two pulses in line 2 (not locked)
        hold_reset();
        release_reset();
        for (int k = 0; k <= 620; k++) begin
            step();
            i_frame_sync = (t == 340 || t == 510 || t == 520) ? 1'b1 : 1'b0;
            if (t == 390) chk("lock_before", 32'(o_locked), 0);
            if (t == 392) begin
                chk("lock_l6", 32'(o_locked), 1);
                chk("gl6_req", 32'(o_pix_req), 1);
                chk("gl6_y", 32'(o_y), 0);
            end
            if (t == 558) chk("lock_hold", 32'(o_locked), 1);
            if (t == 560) begin
                chk("lock_l2", 32'(o_locked), 0);
                chk("gl2_req", 32'(o_pix_req), 1);
                chk("gl2_x", 32'(o_x), 0);
                chk("gl2_y", 32'(o_y), 0);
            end
            if (t == 565) chk("gl2_fstart", 32'(o_frame_start), 1);
            if (t == 616) chk("gl2_absorb_y", 32'(o_y), 1);
        end
        i_frame_sync = 1'b0;

        // Asynchronous reset mid-line 2 with a genlock pulse pending
        hold_reset();
        release_reset();
        for (int k = 0; k <= 130; k++) begin
            step();
            i_frame_sync = (t == 120) ? 1'b1 : 1'b0;
        end
        chk("pre_rst_de", 32'(o_de), 1);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("arst");
        repeat (2) @(negedge clk);
        release_reset();
        nfs = 0;
        for (int k = 0; k < 784; k++) begin
            step();
            if (o_frame_start) nfs++;
            if (t == 0) begin
                chk("rel_req", 32'(o_pix_req), 1);
                chk("rel_x", 32'(o_x), 0);
                chk("rel_y", 32'(o_y), 0);
            end
            if (t == 56) chk("rel_nopend_y", 32'(o_y), 1);
        end
        chk("fstart_count", nfs, 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
